// File: rtl/hsid_band_streamer.sv
// hsid_band_streamer
// Producer for the squared-difference accumulator stream. After a start it
// walks references 0..num_refs-1 and, for each one, bands 0..num_bands-1.
// Each (ref, band) pair reads the pixel and library SRAMs (1-cycle read
// latency). The matching beat is presented to the accumulator one cycle later,
// aligned with the returned read data. The accumulator stream has no
// back-pressure.
// Optional build macro: HSID_BAND_STREAMER_GAP_EN inserts one idle slot after
// the last address of every reference except the final one.
module hsid_band_streamer #(
    parameter int DATA_WIDTH        = 16,
    parameter int DATA_WIDTH_ACC    = 32,
    parameter int HSP_BANDS_WIDTH   = 9,
    parameter int HSP_LIBRARY_WIDTH = 7
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic                                       cancel,
    input  logic [HSP_BANDS_WIDTH-1:0]                 num_bands,
    input  logic [HSP_LIBRARY_WIDTH:0]                 num_refs,
    output logic [HSP_BANDS_WIDTH-1:0]                 pix_addr,
    input  logic [DATA_WIDTH-1:0]                      pix_rdata,
    output logic [HSP_LIBRARY_WIDTH+HSP_BANDS_WIDTH-1:0] lib_addr,
    input  logic [DATA_WIDTH-1:0]                      lib_rdata,
    output logic                                       mem_rd_en,
    output logic                                       acc_clean,
    output logic                                       out_valid,
    output logic [DATA_WIDTH-1:0]                      out_a,
    output logic [DATA_WIDTH-1:0]                      out_b,
    output logic                                       out_last,
    output logic [HSP_LIBRARY_WIDTH-1:0]               out_ref,
    output logic                                       out_init_en,
    output logic [DATA_WIDTH_ACC-1:0]                  out_init_acc,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       error
);

    localparam int BW = HSP_BANDS_WIDTH;
    localparam int LW = HSP_LIBRARY_WIDTH;

    // Largest legal reference count: every index of the library.
    localparam logic [LW:0] REFS_MAX = (LW+1)'(1) << LW;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAN  = 3'd1;
    localparam logic [2:0] ST_STREAM = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]    state_reg;
    logic [2:0]    state_next;
    logic [BW-1:0] band_reg;
    logic [LW-1:0] ref_reg;
    logic [BW-1:0] nb_reg;
    logic [LW:0]   nr_reg;
    logic          gap_reg;

    logic          out_valid_reg;
    logic          out_last_reg;
    logic          out_init_en_reg;
    logic [LW-1:0] out_ref_reg;
    logic          acc_clean_reg;
    logic          done_reg;
    logic          error_reg;

    logic          start_legal;
    logic          band_last;
    logic          ref_last;
    logic          issue;
    logic          active;

    // Run-request legality and position decodes for the address walker.
    always_comb begin
        start_legal = (num_bands != '0) && (num_refs != '0) && (num_refs <= REFS_MAX);
        band_last   = (band_reg == nb_reg - 1'b1);
        ref_last    = ({1'b0, ref_reg} == nr_reg - 1'b1);
        active      = (state_reg != ST_IDLE);
        // An address goes out on every streaming cycle unless a cancel is
        // aborting the run or the walker sits in an inter-reference bubble.
        issue       = (state_reg == ST_STREAM) && !cancel && !gap_reg;
    end

    // Run sequencing: clean pulse, address stream, pipeline drain, done.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start && start_legal) begin
                    state_next = ST_CLEAN;
                end
            end
            ST_CLEAN: begin
                state_next = cancel ? ST_IDLE : ST_STREAM;
            end
            ST_STREAM: begin
                if (cancel) begin
                    state_next = ST_IDLE;
                end else if (issue && band_last && ref_last) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_next = cancel ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register and run-length capture at the accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            nb_reg    <= '0;
            nr_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && start && start_legal) begin
                nb_reg <= num_bands;
                nr_reg <= num_refs;
            end
        end
    end

    // Band/reference walker; a cancel or an idle machine returns it to origin.
    always_ff @(posedge clk) begin
        if (rst) begin
            band_reg <= '0;
            ref_reg  <= '0;
            gap_reg  <= 1'b0;
        end else if (!active || cancel) begin
            band_reg <= '0;
            ref_reg  <= '0;
            gap_reg  <= 1'b0;
        end else if (issue) begin
            if (band_last) begin
                band_reg <= '0;
                ref_reg  <= ref_reg + 1'b1;
`ifdef HSID_BAND_STREAMER_GAP_EN
                // Bubble after every reference except the final one.
                gap_reg  <= !ref_last;
`else
                gap_reg  <= 1'b0;
`endif
            end else begin
                band_reg <= band_reg + 1'b1;
            end
        end else begin
            gap_reg <= 1'b0;
        end
    end

    // Beat qualifiers registered one cycle after the address, lining up with rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg   <= 1'b0;
            out_last_reg    <= 1'b0;
            out_init_en_reg <= 1'b0;
            out_ref_reg     <= '0;
        end else begin
            out_valid_reg   <= issue;
            out_last_reg    <= issue && band_last;
            out_init_en_reg <= issue && (band_reg == '0);
            if (issue) begin
                out_ref_reg <= ref_reg;
            end
        end
    end

    // Status pulses: clean on start or abort, done after drain, error on bad request.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_clean_reg <= 1'b0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            acc_clean_reg <= (!active && start && start_legal) || (active && cancel);
            done_reg      <= (state_reg == ST_DRAIN) && !cancel;
            error_reg     <= !active && start && !start_legal;
        end
    end

    assign pix_addr     = band_reg;
    assign lib_addr     = {ref_reg, band_reg};
    assign mem_rd_en    = issue;
    assign acc_clean    = acc_clean_reg;
    assign out_valid    = out_valid_reg;
    assign out_a        = pix_rdata;
    assign out_b        = lib_rdata;
    assign out_last     = out_last_reg;
    assign out_ref      = out_ref_reg;
    assign out_init_en  = out_init_en_reg;
    assign out_init_acc = '0;
    assign busy         = active;
    assign done         = done_reg;
    assign error        = error_reg;

endmodule

// File: tb/tb_hsid_band_streamer.sv
// Directed testbench for hsid_band_streamer. SRAM models return their own
// address one cycle after a read strobe, so every beat's data is predictable
// from the (ref, band) pair the bench expects.
module tb_hsid_band_streamer;

    localparam int DW  = 16;
    localparam int AW  = 32;
    localparam int BW  = 9;
    localparam int LW  = 7;
`ifdef HSID_BAND_STREAMER_GAP_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif

    logic              clk;
    logic              rst;
    logic              start;
    logic              cancel;
    logic [BW-1:0]     num_bands;
    logic [LW:0]       num_refs;
    logic [BW-1:0]     pix_addr;
    logic [DW-1:0]     pix_rdata;
    logic [LW+BW-1:0]  lib_addr;
    logic [DW-1:0]     lib_rdata;
    logic              mem_rd_en;
    logic              acc_clean;
    logic              out_valid;
    logic [DW-1:0]     out_a;
    logic [DW-1:0]     out_b;
    logic              out_last;
    logic [LW-1:0]     out_ref;
    logic              out_init_en;
    logic [AW-1:0]     out_init_acc;
    logic              busy;
    logic              done;
    logic              error;

    int total_cnt = 0;
    int bad_cnt   = 0;

    hsid_band_streamer #(
        .DATA_WIDTH        (DW),
        .DATA_WIDTH_ACC    (AW),
        .HSP_BANDS_WIDTH   (BW),
        .HSP_LIBRARY_WIDTH (LW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cancel       (cancel),
        .num_bands    (num_bands),
        .num_refs     (num_refs),
        .pix_addr     (pix_addr),
        .pix_rdata    (pix_rdata),
        .lib_addr     (lib_addr),
        .lib_rdata    (lib_rdata),
        .mem_rd_en    (mem_rd_en),
        .acc_clean    (acc_clean),
        .out_valid    (out_valid),
        .out_a        (out_a),
        .out_b        (out_b),
        .out_last     (out_last),
        .out_ref      (out_ref),
        .out_init_en  (out_init_en),
        .out_init_acc (out_init_acc),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM models: mem[i] = i, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            pix_rdata <= {7'd0, pix_addr};
            lib_rdata <= lib_addr;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) else begin
            bad_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full run from IDLE: clean pulse, every beat, optional bubbles, done, idle.
    task automatic run_walk(input int nb, input int nr);
        logic [15:0] exp_b;
        num_bands = BW'(nb);
        num_refs  = (LW+1)'(nr);
        start     = 1'b1;
        step();                                   // cycle 1
        start = 1'b0;
        chk("clean_pulse", acc_clean, 1);
        chk("busy_clean", busy, 1);
        chk("no_valid_c1", out_valid, 0);
        step();                                   // cycle 2
        chk("first_rd_en", mem_rd_en, 1);
        chk("no_valid_c2", out_valid, 0);
        chk("clean_gone", acc_clean, 0);
        for (int r = 0; r < nr; r++) begin
            for (int b = 0; b < nb; b++) begin
                step();
                exp_b = 16'((r << 9) | b);
                chk("beat_valid", out_valid, 1);
                chk("beat_a", out_a, 64'(b));
                chk("beat_b", out_b, 64'(exp_b));
                chk("beat_last", out_last, (b == nb - 1) ? 1 : 0);
                chk("beat_init", out_init_en, (b == 0) ? 1 : 0);
                chk("beat_ref", out_ref, 64'(r));
                chk("beat_no_done", done, 0);
                if (GAP != 0 && b == nb - 1 && r < nr - 1) begin
                    step();
                    chk("gap_slot", out_valid, 0);
                end
            end
        end
        step();
        chk("done_pulse", done, 1);
        chk("done_no_valid", out_valid, 0);
        chk("done_busy", busy, 1);
        step();
        chk("done_clear", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    int beats;
    int dones;
    int lasts;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        cancel    = 1'b0;
        num_bands = '0;
        num_refs  = '0;
        pix_rdata = '0;
        lib_rdata = '0;
        repeat (3) step();

        // Reset state.
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_clean", acc_clean, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_init_acc", out_init_acc, 0);
        rst = 1'b0;
        step();

        // bands=4, refs=2 (beats at cycles 3..10, done at 11 without bubbles).
        run_walk(4, 2);
        // Single-band vectors: every beat is both first and last.
        run_walk(1, 3);
        // bands=3, refs=2: valid 1,1,1,(0),1,1,1.
        run_walk(3, 2);
        // Largest reference count.
        run_walk(1, 128);

        // Illegal requests: one-cycle error, nothing else.
        num_bands = 9'd0; num_refs = 8'd2; start = 1'b1;
        step();
        start = 1'b0;
        chk("err_b0_pulse", error, 1);
        chk("err_b0_busy", busy, 0);
        chk("err_b0_clean", acc_clean, 0);
        chk("err_b0_valid", out_valid, 0);
        step();
        chk("err_b0_clear", error, 0);
        chk("err_b0_rd_en", mem_rd_en, 0);
        num_bands = 9'd4; num_refs = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("err_r0_pulse", error, 1);
        chk("err_r0_busy", busy, 0);
        step();
        num_bands = 9'd4; num_refs = 8'd129; start = 1'b1;
        step();
        start = 1'b0;
        chk("err_rbig_pulse", error, 1);
        chk("err_rbig_clean", acc_clean, 0);
        step();
        chk("err_rbig_clear", error, 0);
        chk("err_rbig_busy", busy, 0);

        // Cancel at cycle 7 of a bands=8, refs=4 run.
        num_bands = 9'd8; num_refs = 8'd4; start = 1'b1;
        step();                                   // cycle 1
        start = 1'b0;
        repeat (6) step();                        // cycle 7
        chk("cxl_pre_valid", out_valid, 1);
        chk("cxl_pre_a", out_a, 4);
        chk("cxl_pre_rd", mem_rd_en, 1);
        cancel = 1'b1;
        #1;
        chk("cxl_rd_off", mem_rd_en, 0);
        step();                                   // cycle 8
        cancel = 1'b0;
        chk("cxl_valid_off", out_valid, 0);
        chk("cxl_clean", acc_clean, 1);
        chk("cxl_idle", busy, 0);
        chk("cxl_no_done", done, 0);
        dones = 0;
        beats = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (done) dones++;
            if (out_valid) beats++;
        end
        chk("cxl_no_late_done", 64'(dones), 0);
        chk("cxl_no_late_beat", 64'(beats), 0);
        chk("cxl_clean_once", acc_clean, 0);
        // Fresh run after cancel behaves normally.
        run_walk(2, 2);

        // start held high through a run with mid-run size changes.
        num_bands = 9'd3; num_refs = 8'd2; start = 1'b1;
        beats = 0; dones = 0; lasts = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (i == 1) begin
                num_bands = 9'd5;
                num_refs  = 8'd3;
            end
            if (out_valid) beats++;
            if (out_last) lasts++;
            if (done) begin
                dones++;
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("held_beats", 64'(beats), 6);
        chk("held_lasts", 64'(lasts), 2);
        chk("held_done_once", 64'(dones), 1);
        chk("held_idle", busy, 0);

        // Reset in the middle of a run.
        num_bands = 9'd3; num_refs = 8'd2; start = 1'b1;
        step();                                   // cycle 1
        start = 1'b0;
        repeat (3) step();                        // cycle 4
        chk("mid_pre_valid", out_valid, 1);
        rst = 1'b1;
        step();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rd", mem_rd_en, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_init", out_init_en, 0);
        chk("mid_rst_ref", out_ref, 0);
        chk("mid_rst_clean", acc_clean, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_addr", lib_addr, 0);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done) dones++;
        end
        chk("mid_rst_no_done", 64'(dones), 0);
        run_walk(3, 2);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
